// File: rtl/mul_div_if.sv
// Operand/result bundle between the E-stage datapath
// and the iterative multiply/divide unit.
interface mul_div_if #(
   parameter int WIDTH = 32
);
   logic             startE;
   logic [1:0]       opE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             cancelE;
   logic             mut_div_stallE;
   logic             busyE;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             result_validE;

   modport master (
      output startE, opE, srcaE, srcbE, cancelE,
      input  mut_div_stallE, busyE, hi_o, lo_o,
      input  result_validE
   );

   modport slave (
      input  startE, opE, srcaE, srcbE, cancelE,
      output mut_div_stallE, busyE, hi_o, lo_o,
      output result_validE
   );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU for the E stage.
// One step per cycle; stalls the pipeline while running.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     resetn,
   mul_div_if.slave md
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] wrk_q, wrk_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic neg_q, neg_d;
   logic nrem_q, nrem_d;
   logic div_q, div_d;
   logic dz_q, dz_d;

   logic             go, sa, sb, stall;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign go    = md.startE & ~md.cancelE;
   assign sa    = ~md.opE[0] & md.srcaE[WIDTH-1];
   assign sb    = ~md.opE[0] & md.srcbE[WIDTH-1];
   assign mag_a = sa ? -md.srcaE : md.srcaE;
   assign mag_b = sb ? -md.srcbE : md.srcbE;

   // acc/wrk form the {hi,lo} shift pair for both ops
   logic [WIDTH:0]     sum, trial;
   logic [WIDTH-1:0]   diff, step_hi, step_lo;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic               ge;

   always_comb begin
      sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
      trial = {acc_q, wrk_q[WIDTH-1]};
      ge    = trial >= {1'b0, opnd_q};
      diff  = trial[WIDTH-1:0] - opnd_q;
      if (div_q) begin
         step_hi = ge ? diff : trial[WIDTH-1:0];
         step_lo = {wrk_q[WIDTH-2:0], ge};
      end else begin
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], wrk_q[WIDTH-1:1]};
      end
      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = dz_q ? '1 : (neg_q ? -step_lo : step_lo);
      rem_fix  = nrem_q ? -step_hi : step_hi;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      wrk_d   = wrk_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      nrem_d  = nrem_q;
      div_d   = div_q;
      dz_d    = dz_q;
      stall   = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall = go;
            if (go) begin
               state_d = BUSY;
               cnt_d   = '0;
               acc_d   = '0;
               wrk_d   = md.opE[1] ? mag_a : mag_b;
               opnd_d  = md.opE[1] ? mag_b : mag_a;
               neg_d   = sa ^ sb;
               nrem_d  = sa;
               div_d   = md.opE[1];
               dz_d    = md.opE[1] & (md.srcbE == '0);
            end
         end
         BUSY: begin
            stall = ~md.cancelE;
            if (md.cancelE) begin
               state_d = IDLE;
            end else begin
               acc_d = step_hi;
               wrk_d = step_lo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  if (div_q) begin
                     hi_d = rem_fix;
                     lo_d = quo_fix;
                  end else begin
                     {hi_d, lo_d} = prod_fix;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         wrk_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         nrem_q  <= 1'b0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         wrk_q   <= wrk_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         nrem_q  <= nrem_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
      end
   end

   assign md.mut_div_stallE = stall;
   assign md.busyE          = state_q != IDLE;
   assign md.result_validE  = (state_q == DONE) & ~md.cancelE;
   assign md.hi_o           = hi_q;
   assign md.lo_o           = lo_q;
endmodule
